// File: rtl/cam_pkg.sv
// Shared camera-pipeline definitions: background-capture state encoding, frame geometry
// defaults and RGB565 field layout.
package cam_pkg;

    localparam int unsigned DEF_FRAME_PIXELS = 76800;
    localparam int unsigned DEF_ADDR_W       = 17;
    localparam int unsigned DEF_BLEND_SHIFT  = 2;

    localparam int unsigned PIX_W = 16;
    localparam int unsigned R_W   = 5;
    localparam int unsigned G_W   = 6;
    localparam int unsigned B_W   = 5;
    localparam int unsigned R_LSB = 11;
    localparam int unsigned G_LSB = 5;
    localparam int unsigned B_LSB = 0;

    typedef enum logic [1:0] {
        StIdle,
        StWaitFrame,
        StCapture,
        StDone
    } cap_state_e;

    // (old*(2^S-1) + live) >> S; the sum never exceeds channel+S bits, so 32 bits is ample.
    function automatic logic [31:0] blend_ch(input logic [31:0] old_ch,
                                             input logic [31:0] live_ch,
                                             input logic [3:0]  shift);
        logic [31:0] weight;
        weight = (32'd1 << shift) - 32'd1;
        return (old_ch * weight + live_ch) >> shift;
    endfunction

endpackage

// File: rtl/rgb565_blend.sv
// Combinational per-channel running-average blend of two RGB565 pixels.
module rgb565_blend
    import cam_pkg::*;
(
    input  logic [PIX_W-1:0] old,
    input  logic [PIX_W-1:0] live,
    input  logic [3:0]       shift,
    output logic [PIX_W-1:0] blended
);

    assign blended = {
        R_W'(blend_ch(32'(old[R_LSB +: R_W]), 32'(live[R_LSB +: R_W]), shift)),
        G_W'(blend_ch(32'(old[G_LSB +: G_W]), 32'(live[G_LSB +: G_W]), shift)),
        B_W'(blend_ch(32'(old[B_LSB +: B_W]), 32'(live[B_LSB +: B_W]), shift))
    };

endmodule

// File: rtl/bg_capture.sv
// Background frame capture: snapshots or running-average blends one video frame into an
// external synchronous RAM, with a two-stage read-modify-write pipeline.
module bg_capture
    import cam_pkg::*;
#(
    parameter int unsigned FRAME_PIXELS = DEF_FRAME_PIXELS,
    parameter int unsigned ADDR_W       = DEF_ADDR_W,
    parameter int unsigned BLEND_SHIFT  = DEF_BLEND_SHIFT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              capture_req,
    input  logic              blend_en,
    input  logic              vsync,
    input  logic              active_area,
    input  logic [PIX_W-1:0]  live_pixel_in,
    input  logic [PIX_W-1:0]  bg_rd_data,
    output logic [ADDR_W-1:0] bg_rd_addr,
    output logic              bg_wr_en,
    output logic [ADDR_W-1:0] bg_wr_addr,
    output logic [PIX_W-1:0]  bg_wr_data,
    output logic              busy,
    output logic              bg_valid,
    output logic              short_frame
);

    cap_state_e state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic req_q, vsync_q;
    logic req_rise, vsync_rise;
    logic blend_mode_q, blend_mode_d;
    logic short_q, short_d;
    logic bg_valid_q, bg_valid_d;
    logic accept, cnt_full;

    logic              s1_valid_q;
    logic [ADDR_W-1:0] s1_addr_q;
    logic [PIX_W-1:0]  s1_pix_q;
    logic [PIX_W-1:0]  blended;

    assign req_rise   = capture_req & ~req_q;
    assign vsync_rise = vsync & ~vsync_q;
    assign cnt_full   = 32'(cnt_q) >= FRAME_PIXELS;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        blend_mode_d = blend_mode_q;
        short_d      = short_q;
        bg_valid_d   = bg_valid_q;
        accept       = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req_rise) begin
                    state_d      = StWaitFrame;
                    // Blending against an invalid background would be garbage.
                    blend_mode_d = blend_en & bg_valid_q;
                end
            end
            StWaitFrame: begin
                if (vsync_rise) begin
                    state_d = StCapture;
                    cnt_d   = '0;
                end
            end
            StCapture: begin
                if (cnt_full) begin
                    state_d = StDone;
                    short_d = 1'b0;
                end else if (vsync_rise) begin
                    state_d = StDone;
                    short_d = 1'b1;
                end else if (active_area) begin
                    accept = 1'b1;
                    cnt_d  = cnt_q + ADDR_W'(1);
                end
            end
            StDone: begin
                // One cycle here lets the final write leave the pipeline before busy drops.
                state_d    = StIdle;
                bg_valid_d = bg_valid_q | ~short_q;
            end
            default: state_d = StIdle;
        endcase
    end

    rgb565_blend u_blend (
        .old     (bg_rd_data),
        .live    (s1_pix_q),
        .shift   (4'(BLEND_SHIFT)),
        .blended (blended)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            req_q        <= 1'b0;
            vsync_q      <= 1'b0;
            blend_mode_q <= 1'b0;
            short_q      <= 1'b0;
            bg_valid_q   <= 1'b0;
            s1_valid_q   <= 1'b0;
            s1_addr_q    <= '0;
            s1_pix_q     <= '0;
            bg_wr_en     <= 1'b0;
            bg_wr_addr   <= '0;
            bg_wr_data   <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            req_q        <= capture_req;
            vsync_q      <= vsync;
            blend_mode_q <= blend_mode_d;
            short_q      <= short_d;
            bg_valid_q   <= bg_valid_d;
            s1_valid_q   <= accept;
            if (accept) begin
                s1_addr_q <= cnt_q;
                s1_pix_q  <= live_pixel_in;
            end
            // RAM read data for s1_addr_q is valid in the cycle after the pixel is accepted.
            bg_wr_en <= s1_valid_q;
            if (s1_valid_q) begin
                bg_wr_addr <= s1_addr_q;
                bg_wr_data <= blend_mode_q ? blended : s1_pix_q;
            end
        end
    end

    assign bg_rd_addr  = cnt_q;
    assign busy        = (state_q != StIdle);
    assign bg_valid    = bg_valid_q;
    assign short_frame = short_q;

endmodule

// File: tb/tb_bg_capture.sv
// Randomized bench for bg_capture with a behavioural background-RAM and write-expectation model.
module tb_bg_capture;

    localparam int unsigned FP = 16;
    localparam int unsigned AW = 5;
    localparam int unsigned BS = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          capture_req = 1'b0;
    logic          blend_en = 1'b0;
    logic          vsync = 1'b0;
    logic          active_area = 1'b0;
    logic [15:0]   live_pixel_in = '0;
    logic [15:0]   bg_rd_data;
    logic [AW-1:0] bg_rd_addr;
    logic          bg_wr_en;
    logic [AW-1:0] bg_wr_addr;
    logic [15:0]   bg_wr_data;
    logic          busy;
    logic          bg_valid;
    logic          short_frame;

    bg_capture #(
        .FRAME_PIXELS (FP),
        .ADDR_W       (AW),
        .BLEND_SHIFT  (BS)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .capture_req   (capture_req),
        .blend_en      (blend_en),
        .vsync         (vsync),
        .active_area   (active_area),
        .live_pixel_in (live_pixel_in),
        .bg_rd_data    (bg_rd_data),
        .bg_rd_addr    (bg_rd_addr),
        .bg_wr_en      (bg_wr_en),
        .bg_wr_addr    (bg_wr_addr),
        .bg_wr_data    (bg_wr_data),
        .busy          (busy),
        .bg_valid      (bg_valid),
        .short_frame   (short_frame)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          addr;
        logic [15:0] data;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [15:0] ram[0:31];
    logic [15:0] ref_bg[0:31];
    logic [15:0] last_wr_data = '0;
    logic [15:0] pix_const = '0;
    bit          ref_valid = 1'b0;
    bit          ref_short = 1'b0;
    int          cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;

    always @(posedge clk) cyc++;

    // External synchronous background RAM.
    always @(posedge clk) begin
        bg_rd_data <= ram[bg_rd_addr];
        if (bg_wr_en) ram[bg_wr_addr] <= bg_wr_data;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    function automatic logic [15:0] ref_blend(input logic [15:0] o, input logic [15:0] l);
        int w, d, r, g, b;
        w = (1 << BS) - 1;
        d = 1 << BS;
        r = (int'(o[15:11]) * w + int'(l[15:11])) / d;
        g = (int'(o[10:5])  * w + int'(l[10:5]))  / d;
        b = (int'(o[4:0])   * w + int'(l[4:0]))   / d;
        return {r[4:0], g[5:0], b[4:0]};
    endfunction

    always @(negedge clk) begin
        if (bg_wr_en) begin
            if (exp_q.size() == 0) begin
                check("unexpected_wr", 32'(bg_wr_en), 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", 32'(bg_wr_addr), mon_e.addr);
                check("wr_data", 32'(bg_wr_data), 32'(mon_e.data));
                check("wr_cycle", cyc, mon_e.cyc);
                ref_bg[mon_e.addr] = mon_e.data;
                last_wr_data = bg_wr_data;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // pmode: 0 = pixel index, 1 = pix_const, 2 = random data.
    task automatic run_capture(input bit blend, input int n_act, input bit end_vsync,
                               input int pmode, input bit gaps, input bit poke);
        int          cnt;
        int          to;
        bit          cur_blend;
        logic [15:0] p;
        exp_t        e;
        cur_blend = blend && ref_valid;
        capture_req = 1'b1;
        blend_en = blend;
        tick();
        capture_req = 1'b0;
        blend_en = 1'($urandom_range(0, 1));
        tick();
        tick();
        vsync = 1'b1;
        tick();
        vsync = 1'b0;
        cnt = 0;
        for (int i = 0; i < n_act; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) tick();
            p = (pmode == 0) ? 16'(i) : (pmode == 1) ? pix_const : 16'($urandom);
            if (poke && i == int'(FP / 2)) capture_req = 1'b1;
            active_area = 1'b1;
            live_pixel_in = p;
            if (cnt < int'(FP)) begin
                e.addr = cnt;
                e.data = cur_blend ? ref_blend(ref_bg[cnt], p) : p;
                e.cyc  = cyc + 2;
                exp_q.push_back(e);
                cnt++;
            end
            tick();
            active_area = 1'b0;
            live_pixel_in = 16'($urandom);
        end
        if (end_vsync) begin
            vsync = 1'b1;
            tick();
            vsync = 1'b0;
        end
        if (cnt == int'(FP)) begin
            ref_valid = 1'b1;
            ref_short = 1'b0;
        end else begin
            ref_short = 1'b1;
        end
        to = 0;
        while (busy && to < 60) begin
            tick();
            to++;
        end
        check("busy_drop", 32'(busy), 32'd0);
        tick();
        capture_req = 1'b0;
        tick();
        tick();
        check("bg_valid", 32'(bg_valid), 32'(ref_valid));
        check("short_frame", 32'(short_frame), 32'(ref_short));
        check("pending_wr", exp_q.size(), 32'd0);
    endtask

    initial begin
        exp_t e;
        bit   sh;
        for (int i = 0; i < 32; i++) begin
            ram[i] = '0;
            ref_bg[i] = '0;
        end
        repeat (3) tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_bg_valid", 32'(bg_valid), 32'd0);
        check("rst_short", 32'(short_frame), 32'd0);
        check("rst_wr_en", 32'(bg_wr_en), 32'd0);
        check("rst_rd_addr", 32'(bg_rd_addr), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        run_capture(1'b0, 16, 1'b0, 0, 1'b0, 1'b0);
        pix_const = 16'hFFFF;
        run_capture(1'b0, 16, 1'b0, 1, 1'b1, 1'b0);
        pix_const = 16'h0000;
        run_capture(1'b1, 16, 1'b0, 1, 1'b1, 1'b0);
        check("blend_ffff_0000", 32'(last_wr_data), 32'h0000BDF7);
        run_capture(1'b0, 10, 1'b1, 2, 1'b1, 1'b0);
        run_capture(1'b1, 20, 1'b0, 2, 1'b0, 1'b1);

        for (int k = 0; k < 6; k++) begin
            sh = 1'($urandom_range(0, 1));
            run_capture(1'($urandom_range(0, 1)),
                        sh ? int'($urandom_range(1, 15)) : int'($urandom_range(16, 20)),
                        sh ? 1'b1 : 1'($urandom_range(0, 1)),
                        2, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Abort a capture with reset after five accepted pixels.
        capture_req = 1'b1;
        blend_en = 1'b0;
        tick();
        capture_req = 1'b0;
        tick();
        vsync = 1'b1;
        tick();
        vsync = 1'b0;
        for (int i = 0; i < 5; i++) begin
            active_area = 1'b1;
            live_pixel_in = 16'($urandom);
            e.addr = i;
            e.data = live_pixel_in;
            e.cyc  = cyc + 2;
            exp_q.push_back(e);
            tick();
        end
        active_area = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_wr_en", 32'(bg_wr_en), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_bg_valid", 32'(bg_valid), 32'd0);
        exp_q.delete();
        ref_valid = 1'b0;
        ref_short = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        run_capture(1'b1, 16, 1'b0, 2, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
